// File: rtl/counter_updn.sv
// counter_updn: parametrised up/down counter with clear, clamped load, wrap/saturate,
// registered terminal-count pulse and sticky overflow flag.
module counter_updn #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic             dec,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             up, dn, lim;
    logic [WIDTH:0]   step_x;

    always_comb begin
        up     = inc & ~dec;
        dn     = dec & ~inc;
        step_x = up ? {1'b0, cnt_q} + 1'b1 : {1'b0, cnt_q} - 1'b1;
        // The extra bit catches both crossings: above MAX going up, borrow out of 0 going down
        lim    = ~clr & ~load & ((up & (step_x > {1'b0, MAX})) | (dn & step_x[WIDTH]));
        cnt_d  = clr ? '0
               : load ? ((load_val > MAX) ? MAX : load_val)
               : lim ? (SATURATE ? cnt_q : (up ? '0 : MAX))
               : (up | dn) ? step_x[WIDTH-1:0]
               : cnt_q;
        tc_d   = lim;
        ovf_d  = lim | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_counter_updn.sv
// tb_counter_updn: directed checks of default, MAX=9 wrap and MAX=9 saturate counters sharing one stimulus.
module tb_counter_updn;

    logic       clk = 1'b0;
    logic       rstn, clr, load, inc, dec, ovf_clr;
    logic [3:0] load_val;
    logic [3:0] cnt_def, cnt_wrp, cnt_sat;
    logic       tc_def, tc_wrp, tc_sat;
    logic       ovf_def, ovf_wrp, ovf_sat;
    int         n_chk = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    counter_updn u_def (
        .clk(clk), .rstn(rstn), .clr(clr), .load(load), .load_val(load_val),
        .inc(inc), .dec(dec), .ovf_clr(ovf_clr), .cnt(cnt_def), .tc(tc_def), .ovf(ovf_def)
    );

    counter_updn #(.WIDTH(4), .MAX(4'd9), .SATURATE(1'b0)) u_wrp (
        .clk(clk), .rstn(rstn), .clr(clr), .load(load), .load_val(load_val),
        .inc(inc), .dec(dec), .ovf_clr(ovf_clr), .cnt(cnt_wrp), .tc(tc_wrp), .ovf(ovf_wrp)
    );

    counter_updn #(.WIDTH(4), .MAX(4'd9), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rstn(rstn), .clr(clr), .load(load), .load_val(load_val),
        .inc(inc), .dec(dec), .ovf_clr(ovf_clr), .cnt(cnt_sat), .tc(tc_sat), .ovf(ovf_sat)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        {clr, load, inc, dec, ovf_clr} = '0;
        load_val = '0;
        step();
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        {clr, load, inc, dec, ovf_clr} = '0;
        load_val = '0;
        #2;
        check("rst_cnt_def", 32'(cnt_def), 0);
        check("rst_tc_def", 32'(tc_def), 0);
        check("rst_ovf_def", 32'(ovf_def), 0);
        check("rst_cnt_sat", 32'(cnt_sat), 0);
        do_reset();

        inc = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("t1_cnt_%0d", k), 32'(cnt_def), k % 16);
            check($sformatf("t1_tc_%0d", k), 32'(tc_def), (k == 16) ? 1 : 0);
            check($sformatf("t1_ovf_%0d", k), 32'(ovf_def), (k >= 16) ? 1 : 0);
        end

        do_reset();
        dec = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            check($sformatf("t2_cnt_%0d", k), 32'(cnt_wrp), (10 - (k % 10)) % 10);
            check($sformatf("t2_tc_%0d", k), 32'(tc_wrp), (k % 10 == 1) ? 1 : 0);
            check($sformatf("t2_ovf_%0d", k), 32'(ovf_wrp), 1);
        end

        do_reset();
        inc = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step();
            check($sformatf("t3_cnt_%0d", k), 32'(cnt_sat), (k < 9) ? k : 9);
            check($sformatf("t3_tc_%0d", k), 32'(tc_sat), (k >= 10) ? 1 : 0);
            check($sformatf("t3_ovf_%0d", k), 32'(ovf_sat), (k >= 10) ? 1 : 0);
        end
        inc = 1'b0;
        dec = 1'b1;
        step();
        check("t3_dec_cnt", 32'(cnt_sat), 8);
        check("t3_dec_tc", 32'(tc_sat), 0);
        check("t3_dec_ovf", 32'(ovf_sat), 1);

        dec = 1'b0;
        clr = 1'b1;
        load = 1'b1;
        load_val = 4'd5;
        inc = 1'b1;
        step();
        check("t4_clr_prio", 32'(cnt_wrp), 0);
        check("t4_clr_tc", 32'(tc_wrp), 0);
        clr = 1'b0;
        inc = 1'b0;
        load_val = 4'd12;
        step();
        check("t4_load_clamp", 32'(cnt_wrp), 9);
        check("t4_load_def", 32'(cnt_def), 12);
        load = 1'b0;
        inc = 1'b1;
        dec = 1'b1;
        step();
        check("t4_cancel_cnt", 32'(cnt_wrp), 9);
        check("t4_cancel_tc", 32'(tc_wrp), 0);

        inc = 1'b0;
        dec = 1'b0;
        ovf_clr = 1'b1;
        step();
        check("t5_ovf_clr", 32'(ovf_wrp), 0);
        inc = 1'b1;
        step();
        check("t5_wrap_cnt", 32'(cnt_wrp), 0);
        check("t5_wrap_tc", 32'(tc_wrp), 1);
        check("t5_set_wins", 32'(ovf_wrp), 1);
        ovf_clr = 1'b0;
        inc = 1'b0;
        clr = 1'b1;
        step();
        check("t5_clr_cnt", 32'(cnt_wrp), 0);
        check("t5_clr_keeps_ovf", 32'(ovf_wrp), 1);
        check("t5_clr_tc", 32'(tc_wrp), 0);

        clr = 1'b0;
        load = 1'b1;
        load_val = 4'd6;
        step();
        load = 1'b0;
        check("t6_pre_cnt", 32'(cnt_wrp), 6);
        check("t6_pre_ovf", 32'(ovf_wrp), 1);
        #2;
        rstn = 1'b0;
        #1;
        check("t6_async_cnt", 32'(cnt_wrp), 0);
        check("t6_async_ovf", 32'(ovf_wrp), 0);
        check("t6_async_tc", 32'(tc_wrp), 0);
        inc = 1'b1;
        step();
        check("t6_held_cnt", 32'(cnt_wrp), 0);
        rstn = 1'b1;
        step();
        check("t6_resume_cnt", 32'(cnt_wrp), 1);
        check("t6_resume_ovf", 32'(ovf_wrp), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/counter_updn.md
# counter_updn

Parametrised up/down counter: successor to the fixed 4-bit increment-only counter. Adds programmable width and modulus, decrement, synchronous clear and load, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag. Used wherever the design needs event counting, timeouts or modulo-N sequencing. With default parameters and `inc` tied high, `dec`/`clr`/`load`/`ovf_clr` tied low, it is cycle-identical to the existing 4-bit counter.

## Interface
- `WIDTH`, default 4: counter width in bits; legal range 1..32.
- `MAX`, default (1<<WIDTH)-1: highest count value (modulus-1). Must satisfy 0 < MAX <= 2^WIDTH-1.
- `SATURATE`, default 0: 0 = wrap at limits, 1 = hold at limits.

Ports:
- `clk`  in  1: clock, all state on rising edge.
- `rstn`  in  1: asynchronous, active-low reset.
- `clr`  in  1: synchronous clear to 0.
- `load`  in  1: synchronous load of `load_val`.
- `load_val`  in  WIDTH: value to load.
- `inc`  in  1: count up one step.
- `dec`  in  1: count down one step.
- `ovf_clr`  in  1: clear sticky `ovf`.
- `cnt`  out  WIDTH: current count, registered.
- `tc`  out  1: terminal-count pulse, registered.
- `ovf`  out  1: sticky limit-crossing flag, registered.

## Operation
- Per-cycle priority: `clr` > `load` > `inc`/`dec`.
- `clr`: `cnt` <= 0. No `tc`, no `ovf` effect.
- `load`: `cnt` <= `load_val` if `load_val` <= MAX, else `cnt` <= MAX (clamp). No `tc`, no `ovf` effect.
- `inc` and `dec` both high: no change (the two requests cancel). No event.
- `inc` only:
  - `cnt` < MAX: `cnt` <= `cnt`+1.
  - `cnt` == MAX: limit event. `cnt` <= 0 in wrap mode; stays MAX in saturate mode.
- `dec` only:
  - `cnt` > 0: `cnt` <= `cnt`-1.
  - `cnt` == 0: limit event. `cnt` <= MAX in wrap mode; stays 0 in saturate mode.
- Neither request: hold.
- Limit event:
  - Produces `tc`=1 on the next cycle.
  - Sets `ovf`.
  - Applies in both modes.
- `tc` is 0 in every cycle not following a limit event. Consecutive limit events, e.g. saturated with `inc` held, give `tc` high continuously.
- `ovf`:
  - Set by a limit event.
  - Cleared by `ovf_clr`.
  - A simultaneous limit event and `ovf_clr` leaves `ovf`=1 (set wins).
  - Not affected by `clr` or `load`.
- Arithmetic is done in WIDTH+1 bits internally. Comparisons with MAX are unsigned. `cnt` never exceeds MAX.
- No state machine beyond the count register and two flag flops.

## Timing
- Reset values, asynchronous on `rstn` low and held while low: `cnt`=0, `tc`=0, `ovf`=0.
- Reset asserted mid-count forces all three outputs to 0 immediately, with no clock needed. Counting resumes on the first rising edge after `rstn` rises.
- Latency is one cycle for every input: a request sampled at edge N is visible on `cnt`/`tc`/`ovf` after edge N.
- All outputs come directly from flops. No combinational input-to-output path.
- Sustained `inc`: `cnt` advances one per cycle. `tc` pulses once per MAX+1 cycles in wrap mode.

## Test plan
1. Defaults, `inc`=1 from reset release, 20 clocks:
   - `cnt` = 1,2,…,15,0,1,… on successive edges.
   - `tc`=1 only in the cycle where `cnt`=0 after 15.
   - `ovf`=1 from that cycle on.
2. WIDTH=4, MAX=9, wrap, `dec`=1 from 0:
   - `cnt` = 9,8,…,0,9.
   - `tc` high in each cycle `cnt` shows 9 after a wrap.
   - `ovf` set after the first edge.
3. MAX=9, SATURATE=1, `inc`=1 held 15 cycles from 0:
   - `cnt` reaches 9 and stays.
   - `tc` high every cycle after the first attempt past 9.
   - `ovf`=1.
   - Then `dec` one cycle gives 8, and `tc` goes to 0.
4. Priority checks:
   - `clr`, `load`=1 (`load_val`=5) and `inc` in the same cycle → `cnt`=0.
   - `load` with `load_val`=12, MAX=9 → `cnt`=9.
   - `inc`=`dec`=1 → `cnt` unchanged.
5. `ovf` handling:
   - `ovf_clr` alone clears `ovf`.
   - `ovf_clr` in the same cycle as a wrap (`cnt`=MAX, `inc`) → `ovf` stays 1.
   - `clr` does not clear `ovf`.
6. Async reset mid-count:
   - Drop `rstn` between edges with `cnt`=6, `ovf`=1 → all outputs 0 before the next edge.
   - Release with `inc`=1 → `cnt`=1 on the first edge after release.
